// File: rtl/pwm_capture_if.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture_if
// Description : Control/result bundle of the PWM capture unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface pwm_capture_if #(
    parameter int CNT_WIDTH = 16,
    parameter int PSC_WIDTH = 16
);
    logic                 en_i;
    logic                 clr_i;
    logic [PSC_WIDTH-1:0] psc_i;
    logic                 pwm_i;
    logic [CNT_WIDTH-1:0] period_o;
    logic [CNT_WIDTH-1:0] high_o;
    logic                 valid_o;
    logic                 ovf_o;
    logic                 busy_o;

    modport slave (
        input  en_i, clr_i, psc_i, pwm_i,
        output period_o, high_o, valid_o, ovf_o, busy_o
    );

    modport master (
        output en_i, clr_i, psc_i, pwm_i,
        input  period_o, high_o, valid_o, ovf_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : pwm_capture
// Description : Measures period and high time of an external PWM input in
//               prescaled ticks, with valid strobe and sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_capture #(
    parameter int CNT_WIDTH = 16,
    parameter int PSC_WIDTH = 16
) (
    input  logic          clk_i,
    input  logic          rst_i,
    pwm_capture_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HIGH = 2'd2,
        ST_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_cnt_max = '1;
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);
    localparam logic [PSC_WIDTH-1:0] c_psc_one = PSC_WIDTH'(1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_s1, r_s2, r_s3;
    logic [PSC_WIDTH-1:0] r_psc_q;
    logic [PSC_WIDTH-1:0] r_psc_cnt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_high_cap;
    logic [CNT_WIDTH-1:0] r_period;
    logic [CNT_WIDTH-1:0] r_high;
    logic                 r_valid;
    logic                 r_ovf;

    logic                 w_rise, w_fall, w_tick, w_sat, w_running;
    logic [CNT_WIDTH-1:0] w_cap;
    logic                 w_start, w_latch_high, w_done, w_ovf_set;

    assign w_rise    = r_s2 & ~r_s3;
    assign w_fall    = ~r_s2 & r_s3;
    assign w_tick    = (r_psc_cnt == r_psc_q);
    assign w_running = (r_state == ST_HIGH) || (r_state == ST_LOW);
    // Captured value includes the tick landing in the edge cycle itself.
    assign w_cap     = r_cnt + (w_tick ? c_cnt_one : '0);
    assign w_sat     = w_running && (r_cnt == c_cnt_max) && w_tick;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_start      = 1'b0;
        w_latch_high = 1'b0;
        w_done       = 1'b0;
        w_ovf_set    = 1'b0;
        if (!bus.en_i) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_ARM;
                ST_ARM: begin
                    if (w_rise) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (w_sat) begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = ST_ARM;
                    end else if (w_fall) begin
                        w_latch_high = 1'b1;
                        w_state_nxt  = ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (w_sat) begin
                        w_ovf_set   = 1'b1;
                        w_state_nxt = ST_ARM;
                    end else if (w_rise) begin
                        w_done      = 1'b1;
                        w_start     = 1'b1;
                        w_state_nxt = ST_HIGH;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_s1       <= 1'b0;
            r_s2       <= 1'b0;
            r_s3       <= 1'b0;
            r_psc_q    <= '0;
            r_psc_cnt  <= '0;
            r_cnt      <= '0;
            r_high_cap <= '0;
            r_period   <= '0;
            r_high     <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_s1    <= bus.pwm_i;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_valid <= w_done;

            if (w_done) begin
                r_period <= w_cap;
                r_high   <= r_high_cap;
            end
            if (w_latch_high) begin
                r_high_cap <= w_cap;
            end

            // A new overflow outranks a simultaneous clear request.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (bus.clr_i) begin
                r_ovf <= 1'b0;
            end

            // Divisor is frozen for the whole period that starts at a rise.
            if ((r_state == ST_ARM) || w_start) begin
                r_psc_q <= bus.psc_i;
            end

            if (w_start || !w_running) begin
                r_cnt     <= '0;
                r_psc_cnt <= '0;
            end else if (w_tick) begin
                r_cnt     <= r_cnt + c_cnt_one;
                r_psc_cnt <= '0;
            end else begin
                r_psc_cnt <= r_psc_cnt + c_psc_one;
            end
        end
    end

    assign bus.period_o = r_period;
    assign bus.high_o   = r_high;
    assign bus.valid_o  = r_valid;
    assign bus.ovf_o    = r_ovf;
    assign bus.busy_o   = w_running;
endmodule
`default_nettype wire

// File: tb/tb_pwm_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_capture
// Description : Randomized and directed scoreboard bench for pwm_capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_capture;
    localparam int CW = 8;
    localparam int PW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pwm_capture_if #(.CNT_WIDTH(CW), .PSC_WIDTH(PW)) bus ();
    pwm_capture #(.CNT_WIDTH(CW), .PSC_WIDTH(PW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [CW-1:0] q_per[$];
    logic [CW-1:0] q_high[$];

    // Reference model: pin-level high/low durations of the open period and
    // the divisor in force when it started.
    bit m_open = 1'b0;
    int m_h = 0, m_l = 0, m_p = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pin_rise();
        if (m_open) begin
            q_per.push_back(CW'((m_h + m_l) / (m_p + 1)));
            q_high.push_back(CW'(m_h / (m_p + 1)));
        end
        m_p    = int'(bus.psc_i);
        m_open = 1'b1;
        bus.pwm_i = 1'b1;
    endtask

    task automatic period(input int h, input int l, input int new_psc = -1);
        pin_rise();
        m_h = h;
        m_l = l;
        if (new_psc >= 0) begin
            wclk(h / 2);
            bus.psc_i = PW'(new_psc);
            wclk(h - h / 2);
        end else begin
            wclk(h);
        end
        bus.pwm_i = 1'b0;
        wclk(l);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q_per.size() != 0 && n < 50) begin
            wclk(1);
            n++;
        end
        chk("drain_timeout", q_per.size(), 0);
    endtask

    // Close the last period, then park the DUT back in ARM with the pin low.
    task automatic finish_run();
        pin_rise();
        m_open = 1'b0;
        wait_drain();
        bus.en_i = 1'b0;
        wclk(2);
        bus.pwm_i = 1'b0;
        bus.en_i  = 1'b1;
        wclk(4);
    endtask

    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            if (q_per.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got valid=1 period=%0d high=%0d, expected no valid",
                         bus.period_o, bus.high_o);
            end else begin
                chk("period", int'(bus.period_o), int'(q_per.pop_front()));
                chk("high", int'(bus.high_o), int'(q_high.pop_front()));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        bus.en_i  = 1'b0;
        bus.clr_i = 1'b0;
        bus.psc_i = '0;
        bus.pwm_i = 1'b0;
        wclk(3);
        chk("rst_period", int'(bus.period_o), 0);
        chk("rst_high", int'(bus.high_o), 0);
        chk("rst_valid", int'(bus.valid_o), 0);
        chk("rst_ovf", int'(bus.ovf_o), 0);
        chk("rst_busy", int'(bus.busy_o), 0);
        rst = 1'b0;
        wclk(2);

        // 30/70 at psc 0, then drop enable during LOW.
        bus.en_i = 1'b1;
        wclk(4);
        chk("arm_busy", int'(bus.busy_o), 0);
        repeat (4) period(30, 70);
        pin_rise();
        m_open = 1'b0;
        wclk(30);
        bus.pwm_i = 1'b0;
        wclk(20);
        wait_drain();
        chk("low_busy", int'(bus.busy_o), 1);
        bus.en_i = 1'b0;
        wclk(1);
        chk("endrop_busy", int'(bus.busy_o), 0);
        wclk(150);
        chk("endrop_period", int'(bus.period_o), 100);
        chk("endrop_high", int'(bus.high_o), 30);
        bus.en_i = 1'b1;
        wclk(4);

        // Prescaler 3, switched to 1 mid-high.
        bus.psc_i = PW'(3);
        wclk(2);
        period(40, 60);
        period(40, 60, 1);
        period(40, 60);
        finish_run();

        // Stuck-low saturation, clear, then stuck-high saturation with clear.
        bus.psc_i = '0;
        wclk(2);
        chk("pre_ovf", int'(bus.ovf_o), 0);
        bus.pwm_i = 1'b1;
        wclk(20);
        bus.pwm_i = 1'b0;
        wclk(280);
        chk("sat_ovf", int'(bus.ovf_o), 1);
        chk("sat_busy", int'(bus.busy_o), 0);
        chk("sat_period", int'(bus.period_o), 50);
        chk("sat_high", int'(bus.high_o), 20);
        bus.clr_i = 1'b1;
        wclk(1);
        bus.clr_i = 1'b0;
        chk("clr_ovf", int'(bus.ovf_o), 0);
        bus.pwm_i = 1'b1;
        wclk(258);
        bus.clr_i = 1'b1;
        wclk(1);
        bus.clr_i = 1'b0;
        chk("setclr_ovf", int'(bus.ovf_o), 1);
        wclk(1);
        chk("setclr_hold", int'(bus.ovf_o), 1);
        chk("setclr_busy", int'(bus.busy_o), 0);
        bus.pwm_i = 1'b0;
        wclk(4);
        bus.clr_i = 1'b1;
        wclk(1);
        bus.clr_i = 1'b0;

        // Input already high when enabled.
        bus.en_i  = 1'b0;
        bus.pwm_i = 1'b1;
        wclk(5);
        bus.en_i = 1'b1;
        wclk(40);
        chk("prehigh_busy", int'(bus.busy_o), 0);
        bus.pwm_i = 1'b0;
        wclk(10);
        period(30, 70);
        period(30, 70);
        finish_run();

        // Asynchronous reset in the middle of a high phase.
        pin_rise();
        m_open = 1'b0;
        wclk(10);
        chk("prerst_busy", int'(bus.busy_o), 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_period", int'(bus.period_o), 0);
        chk("arst_high", int'(bus.high_o), 0);
        chk("arst_valid", int'(bus.valid_o), 0);
        chk("arst_ovf", int'(bus.ovf_o), 0);
        chk("arst_busy", int'(bus.busy_o), 0);
        bus.pwm_i = 1'b0;
        wclk(2);
        rst = 1'b0;
        wclk(4);
        period(25, 35);
        period(25, 35);
        finish_run();

        // Randomized batches; the last one uses minimal widths at psc 0.
        for (int b = 0; b < 5; b++) begin
            p = (b == 4) ? 0 : int'($urandom_range(0, 3));
            bus.psc_i = PW'(p);
            wclk(2);
            for (int i = 0; i < 6; i++) begin
                if (b == 4) period(int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
                else        period(int'($urandom_range(1, 40)), int'($urandom_range(1, 40)));
            end
            finish_run();
        end

        wait_drain();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
